// File: rtl/gobou_out_packer_pkg.sv
// Shared widths, packing ratio and FSM encoding for the gobou output packer.
package gobou_out_packer_pkg;
  localparam int DWIDTH   = 16;
  localparam int MEMWIDTH = 32;
  localparam int MEMSIZE  = 12;
  localparam int CNTWIDTH = 16;
  localparam int RATIO    = MEMWIDTH / DWIDTH;
  localparam int SLOTW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [SLOTW-1:0] LAST_SLOT = SLOTW'(RATIO - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/gobou_out_packer_if.sv
// Request/pixel stream and memory write port of the gobou output packer.
interface gobou_out_packer_if;
  import gobou_out_packer_pkg::*;

  logic                       req;
  logic        [MEMSIZE-1:0]  out_base;
  logic        [CNTWIDTH-1:0] out_size;
  logic                       pixel_valid;
  logic signed [DWIDTH-1:0]   pixel_in;
  logic                       mem_we;
  logic        [MEMSIZE-1:0]  mem_addr;
  logic        [MEMWIDTH-1:0] mem_wdata;
  logic                       busy;
  logic                       ack;

  modport master (
    output req, out_base, out_size, pixel_valid, pixel_in,
    input  mem_we, mem_addr, mem_wdata, busy, ack
  );

  modport slave (
    input  req, out_base, out_size, pixel_valid, pixel_in,
    output mem_we, mem_addr, mem_wdata, busy, ack
  );
endinterface

// File: rtl/gobou_pack_ctrl.sv
// Packer control: run FSM, pixel/slot counters, word address and busy/ack.
module gobou_pack_ctrl
  import gobou_out_packer_pkg::*;
(
  input  logic                clk,
  input  logic                xrst,
  input  logic                i_req,
  input  logic [MEMSIZE-1:0]  i_base,
  input  logic [CNTWIDTH-1:0] i_size,
  input  logic                i_pixel_valid,
  output state_t              o_state,
  output logic                o_start,
  output logic                o_accept,
  output logic                o_wr,
  output logic [SLOTW-1:0]    o_slot,
  output logic [MEMSIZE-1:0]  o_waddr,
  output logic                o_busy,
  output logic                o_ack
);
  state_t              r_state, w_nxt;
  logic [CNTWIDTH-1:0] r_size, r_cnt;
  logic [SLOTW-1:0]    r_slot;
  logic [MEMSIZE-1:0]  r_addr;
  logic                r_busy, r_ack;
  logic                w_start, w_accept, w_last, w_full;

  assign w_last = (r_cnt + CNTWIDTH'(1)) == r_size;
  assign w_full = (r_slot == LAST_SLOT);

  always_comb begin
    w_nxt    = r_state;
    w_start  = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: if (i_req) begin
        w_start = 1'b1;
        w_nxt   = (i_size == '0) ? S_DONE : S_RUN;
      end
      S_RUN: if (i_pixel_valid) begin
        w_accept = 1'b1;
        if (w_last) w_nxt = w_full ? S_DONE : S_FLUSH;
      end
      S_FLUSH: w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      r_state <= S_IDLE;
      r_size  <= '0;
      r_cnt   <= '0;
      r_slot  <= '0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt != S_IDLE);
      r_ack   <= (r_state == S_DONE);
      if (w_start) begin
        r_size <= i_size;
        r_addr <= i_base;
        r_cnt  <= '0;
        r_slot <= '0;
      end else if (w_accept) begin
        r_cnt  <= r_cnt + CNTWIDTH'(1);
        r_slot <= w_full ? '0 : r_slot + SLOTW'(1);
        // The word address moves on as soon as a word is handed to the write port.
        if (w_full || w_last) r_addr <= r_addr + MEMSIZE'(1);
      end
    end
  end

  assign o_state  = r_state;
  assign o_start  = w_start;
  assign o_accept = w_accept;
  assign o_wr     = w_accept && (w_full || w_last);
  assign o_slot   = r_slot;
  assign o_waddr  = r_addr;
  assign o_busy   = r_busy;
  assign o_ack    = r_ack;
endmodule

// File: rtl/gobou_out_packer.sv
// Packs signed pixels into memory words and issues registered writes.
// Optional GOBOU_PACK_STATS_EN adds wr_count and drop_err outputs.
module gobou_out_packer
  import gobou_out_packer_pkg::*;
(
  input  logic               clk,
  input  logic               xrst,
`ifdef GOBOU_PACK_STATS_EN
  output logic [MEMSIZE:0]   wr_count,
  output logic               drop_err,
`endif
  gobou_out_packer_if.slave  bus
);
  state_t              w_state;
  logic                w_start, w_accept, w_wr;
  logic [SLOTW-1:0]    w_slot;
  logic [MEMSIZE-1:0]  w_waddr;
  logic [MEMWIDTH-1:0] w_word;
  logic [MEMWIDTH-1:0] r_pack, r_wdata;
  logic [MEMSIZE-1:0]  r_addr;
  logic                r_we;

  gobou_pack_ctrl u_ctrl (
    .clk           (clk),
    .xrst          (xrst),
    .i_req         (bus.req),
    .i_base        (bus.out_base),
    .i_size        (bus.out_size),
    .i_pixel_valid (bus.pixel_valid),
    .o_state       (w_state),
    .o_start       (w_start),
    .o_accept      (w_accept),
    .o_wr          (w_wr),
    .o_slot        (w_slot),
    .o_waddr       (w_waddr),
    .o_busy        (bus.busy),
    .o_ack         (bus.ack)
  );

  // Upper slots of r_pack are always zero, so a flushed partial word needs no masking.
  always_comb begin
    w_word = r_pack;
    w_word[int'(w_slot)*DWIDTH +: DWIDTH] = bus.pixel_in;
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      r_pack  <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
    end else begin
      r_we <= w_wr;
      if (w_start) r_pack <= '0;
      else if (w_accept) r_pack <= w_wr ? '0 : w_word;
      if (w_wr) begin
        r_wdata <= w_word;
        r_addr  <= w_waddr;
      end
    end
  end

  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

`ifdef GOBOU_PACK_STATS_EN
  logic [MEMSIZE:0] r_wr_count;
  logic             r_drop;

  always_ff @(posedge clk) begin
    if (!xrst) begin
      r_wr_count <= '0;
      r_drop     <= 1'b0;
    end else if (w_start) begin
      r_wr_count <= '0;
      r_drop     <= 1'b0;
    end else begin
      if (r_we) r_wr_count <= r_wr_count + (MEMSIZE+1)'(1);
      if (bus.pixel_valid && (w_state == S_FLUSH || w_state == S_DONE)) r_drop <= 1'b1;
    end
  end

  assign wr_count = r_wr_count;
  assign drop_err = r_drop;
`endif
endmodule

// File: tb/tb_gobou_out_packer.sv
// Directed bench for gobou_out_packer: packing, flush, wrap, reset abort, ignored inputs.
module tb_gobou_out_packer;
  import gobou_out_packer_pkg::*;

  logic clk = 1'b0;
  logic xrst = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  gobou_out_packer_if bus();

`ifdef GOBOU_PACK_STATS_EN
  logic [MEMSIZE:0] wr_count;
  logic             drop_err;
  gobou_out_packer dut (.clk(clk), .xrst(xrst), .wr_count(wr_count), .drop_err(drop_err), .bus(bus));
`else
  gobou_out_packer dut (.clk(clk), .xrst(xrst), .bus(bus));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write collector
  logic [MEMSIZE-1:0]  wr_addr [64];
  logic [MEMWIDTH-1:0] wr_data [64];
  int                  wr_cyc  [64];
  int                  wr_total = 0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr[wr_total % 64] <= bus.mem_addr;
      wr_data[wr_total % 64] <= bus.mem_wdata;
      wr_cyc[wr_total % 64]  <= cyc;
      wr_total <= wr_total + 1;
    end
  end

  int ack_cyc;
  int req_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [MEMSIZE-1:0] base, input logic [CNTWIDTH-1:0] size);
    bus.req      = 1'b1;
    bus.out_base = base;
    bus.out_size = size;
    req_cyc      = cyc;
    tick();
    bus.req      = 1'b0;
  endtask

  task automatic pix(input logic [DWIDTH-1:0] p);
    bus.pixel_valid = 1'b1;
    bus.pixel_in    = p;
    tick();
    bus.pixel_valid = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.ack) begin
        found   = 1;
        ack_cyc = cyc;
      end else tick();
    end
    total_cnt++;
    if (!found) $display("FAIL %s_ack_timeout got no ack expected ack within 40 cycles", name);
    else pass_cnt++;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    xrst = 1'b0;
    repeat (3) tick();
    total_cnt += 5;
    if (bus.mem_we !== 1'b0) $display("FAIL rst_we got %b expected 0", bus.mem_we); else pass_cnt++;
    if (bus.mem_addr !== '0) $display("FAIL rst_addr got %h expected 0", bus.mem_addr); else pass_cnt++;
    if (bus.mem_wdata !== '0) $display("FAIL rst_wdata got %h expected 0", bus.mem_wdata); else pass_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b expected 0", bus.busy); else pass_cnt++;
    if (bus.ack !== 1'b0) $display("FAIL rst_ack got %b expected 0", bus.ack); else pass_cnt++;
    xrst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int w0 = wr_total;
    start_run(12'h010, 16'd4);
    total_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL b2b_busy got %b expected 1", bus.busy); else pass_cnt++;
    pix(16'd1); pix(16'd2); pix(16'd3); pix(16'd4);
    wait_ack("b2b");
    total_cnt += 7;
    if (wr_total - w0 !== 2) $display("FAIL b2b_nwr got %0d expected 2", wr_total - w0); else pass_cnt++;
    if (wr_data[w0 % 64] !== 32'h0002_0001) $display("FAIL b2b_d0 got %h expected 00020001", wr_data[w0 % 64]); else pass_cnt++;
    if (wr_addr[w0 % 64] !== 12'h010) $display("FAIL b2b_a0 got %h expected 010", wr_addr[w0 % 64]); else pass_cnt++;
    if (wr_data[(w0+1) % 64] !== 32'h0004_0003) $display("FAIL b2b_d1 got %h expected 00040003", wr_data[(w0+1) % 64]); else pass_cnt++;
    if (wr_addr[(w0+1) % 64] !== 12'h011) $display("FAIL b2b_a1 got %h expected 011", wr_addr[(w0+1) % 64]); else pass_cnt++;
    if (ack_cyc - wr_cyc[(w0+1) % 64] !== 1) $display("FAIL b2b_ack_lat got %0d expected 1", ack_cyc - wr_cyc[(w0+1) % 64]); else pass_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL b2b_busy_end got %b expected 0", bus.busy); else pass_cnt++;
`ifdef GOBOU_PACK_STATS_EN
    total_cnt++;
    if (wr_count !== 13'd2) $display("FAIL b2b_wr_count got %0d expected 2", wr_count); else pass_cnt++;
`endif
  endtask

  task automatic test_flush();
    int w0 = wr_total;
    start_run(12'h020, 16'd3);
    pix(16'h7FFF); pix(16'h8000); pix(16'h0005);
    wait_ack("flush");
    total_cnt += 5;
    if (wr_total - w0 !== 2) $display("FAIL flush_nwr got %0d expected 2", wr_total - w0); else pass_cnt++;
    if (wr_data[w0 % 64] !== 32'h8000_7FFF) $display("FAIL flush_d0 got %h expected 80007fff", wr_data[w0 % 64]); else pass_cnt++;
    if (wr_addr[w0 % 64] !== 12'h020) $display("FAIL flush_a0 got %h expected 020", wr_addr[w0 % 64]); else pass_cnt++;
    if (wr_data[(w0+1) % 64] !== 32'h0000_0005) $display("FAIL flush_d1 got %h expected 00000005", wr_data[(w0+1) % 64]); else pass_cnt++;
    if (wr_addr[(w0+1) % 64] !== 12'h021) $display("FAIL flush_a1 got %h expected 021", wr_addr[(w0+1) % 64]); else pass_cnt++;
  endtask

  task automatic test_zero_size();
    int w0 = wr_total;
    start_run(12'h0AA, 16'd0);
    wait_ack("zero");
    total_cnt += 2;
    if (wr_total - w0 !== 0) $display("FAIL zero_nwr got %0d expected 0", wr_total - w0); else pass_cnt++;
    if (ack_cyc - req_cyc !== 2) $display("FAIL zero_ack_lat got %0d expected 2", ack_cyc - req_cyc); else pass_cnt++;
  endtask

  task automatic test_wrap_gaps();
    int w0 = wr_total;
    start_run(12'hFFF, 16'd4);
    pix(16'h1234); repeat (3) tick();
    pix(16'hABCD); repeat (3) tick();
    pix(16'h0001); repeat (3) tick();
    pix(16'hFFFF);
    wait_ack("wrap");
    total_cnt += 5;
    if (wr_total - w0 !== 2) $display("FAIL wrap_nwr got %0d expected 2", wr_total - w0); else pass_cnt++;
    if (wr_data[w0 % 64] !== 32'hABCD_1234) $display("FAIL wrap_d0 got %h expected abcd1234", wr_data[w0 % 64]); else pass_cnt++;
    if (wr_addr[w0 % 64] !== 12'hFFF) $display("FAIL wrap_a0 got %h expected fff", wr_addr[w0 % 64]); else pass_cnt++;
    if (wr_data[(w0+1) % 64] !== 32'hFFFF_0001) $display("FAIL wrap_d1 got %h expected ffff0001", wr_data[(w0+1) % 64]); else pass_cnt++;
    if (wr_addr[(w0+1) % 64] !== 12'h000) $display("FAIL wrap_a1 got %h expected 000", wr_addr[(w0+1) % 64]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int w0 = wr_total;
    start_run(12'h030, 16'd4);
    pix(16'h0009);
    xrst = 1'b0;
    tick();
    total_cnt += 5;
    if (bus.mem_we !== 1'b0) $display("FAIL mid_we got %b expected 0", bus.mem_we); else pass_cnt++;
    if (bus.mem_addr !== '0) $display("FAIL mid_addr got %h expected 0", bus.mem_addr); else pass_cnt++;
    if (bus.mem_wdata !== '0) $display("FAIL mid_wdata got %h expected 0", bus.mem_wdata); else pass_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL mid_busy got %b expected 0", bus.busy); else pass_cnt++;
    if (bus.ack !== 1'b0) $display("FAIL mid_ack got %b expected 0", bus.ack); else pass_cnt++;
    xrst = 1'b1;
    pix(16'h000A);
    tick();
    total_cnt++;
    if (wr_total - w0 !== 0) $display("FAIL mid_nwr got %0d expected 0", wr_total - w0); else pass_cnt++;
    start_run(12'h040, 16'd2);
    pix(16'h0007); pix(16'h0008);
    wait_ack("mid_rerun");
    total_cnt += 3;
    if (wr_total - w0 !== 1) $display("FAIL mid_rerun_nwr got %0d expected 1", wr_total - w0); else pass_cnt++;
    if (wr_data[w0 % 64] !== 32'h0008_0007) $display("FAIL mid_rerun_d got %h expected 00080007", wr_data[w0 % 64]); else pass_cnt++;
    if (wr_addr[w0 % 64] !== 12'h040) $display("FAIL mid_rerun_a got %h expected 040", wr_addr[w0 % 64]); else pass_cnt++;
  endtask

  task automatic test_ignored_inputs();
    int w0 = wr_total;
    pix(16'h5555);
    start_run(12'h050, 16'd2);
    pix(16'h0011);
    bus.req      = 1'b1;
    bus.out_base = 12'h060;
    bus.out_size = 16'd9;
    pix(16'h0022);
    bus.req = 1'b0;
    pix(16'h0033);
`ifdef GOBOU_PACK_STATS_EN
    total_cnt++;
    if (drop_err !== 1'b1) $display("FAIL ign_drop_err got %b expected 1", drop_err); else pass_cnt++;
`endif
    wait_ack("ign");
    repeat (6) tick();
    total_cnt += 3;
    if (wr_total - w0 !== 1) $display("FAIL ign_nwr got %0d expected 1", wr_total - w0); else pass_cnt++;
    if (wr_data[w0 % 64] !== 32'h0022_0011) $display("FAIL ign_d got %h expected 00220011", wr_data[w0 % 64]); else pass_cnt++;
    if (wr_addr[w0 % 64] !== 12'h050) $display("FAIL ign_a got %h expected 050", wr_addr[w0 % 64]); else pass_cnt++;
  endtask

  initial begin
    bus.req         = 1'b0;
    bus.out_base    = '0;
    bus.out_size    = '0;
    bus.pixel_valid = 1'b0;
    bus.pixel_in    = '0;
    test_reset();
    test_back_to_back();
    test_flush();
    test_zero_size();
    test_wrap_gaps();
    test_reset_mid_run();
    test_ignored_inputs();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
